// File: rtl/shift_arbiter_if.sv
// Bundle between two requesters, the shared shifter and the arbiter.
// slave = arbiter side, master = environment side.
interface shift_arbiter_if #(
  parameter int DATA_SIZE = 4,
  parameter int SEL_WIDTH = 2
);

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [DATA_SIZE-1:0] req0_data;
  logic [DATA_SIZE-1:0] req1_data;
  logic [SEL_WIDTH-1:0] req0_select;
  logic [SEL_WIDTH-1:0] req1_select;
  logic                 req0_rot;
  logic                 req1_rot;
  logic                 req0_dir;
  logic                 req1_dir;

  logic [DATA_SIZE-1:0] sh_data_in;
  logic [SEL_WIDTH-1:0] sh_select;
  logic                 sh_rotation;
  logic                 sh_direction;
  logic                 sh_start;
  logic [DATA_SIZE-1:0] sh_data_out;

  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [DATA_SIZE-1:0] rsp_data;
  logic                 busy;

  modport slave (
    input  req_valid,
    input  req0_data,
    input  req1_data,
    input  req0_select,
    input  req1_select,
    input  req0_rot,
    input  req1_rot,
    input  req0_dir,
    input  req1_dir,
    input  sh_data_out,
    input  rsp_ready,
    output req_ready,
    output sh_data_in,
    output sh_select,
    output sh_rotation,
    output sh_direction,
    output sh_start,
    output rsp_valid,
    output rsp_data,
    output busy
  );

  modport master (
    output req_valid,
    output req0_data,
    output req1_data,
    output req0_select,
    output req1_select,
    output req0_rot,
    output req1_rot,
    output req0_dir,
    output req1_dir,
    output sh_data_out,
    output rsp_ready,
    input  req_ready,
    input  sh_data_in,
    input  sh_select,
    input  sh_rotation,
    input  sh_direction,
    input  sh_start,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one registered shifter between two requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module shift_arbiter #(
  parameter int DATA_SIZE = 4,
  parameter int SEL_WIDTH = 2
) (
  input logic            clk,
  input logic            rst,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t               state;
  logic                 last_grant;
  logic                 gnt_q;
  logic [DATA_SIZE-1:0] data_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic                 rot_q;
  logic                 dir_q;
  logic [DATA_SIZE-1:0] rsp_q;
  logic                 start_q;
  logic [1:0]           valid_q;
  logic                 busy_q;
  logic [1:0]           grant;

  // Round-robin pick; only offered in IDLE and never during a reset cycle.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !rst) begin
      unique case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.req_ready    = grant;
  assign bus.sh_data_in   = data_q;
  assign bus.sh_select    = sel_q;
  assign bus.sh_rotation  = rot_q;
  assign bus.sh_direction = dir_q;
  assign bus.sh_start     = start_q;
  assign bus.rsp_valid    = valid_q;
  assign bus.rsp_data     = rsp_q;
  assign bus.busy         = busy_q;

  // Transaction FSM with registered strobe, response and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      data_q     <= '0;
      sel_q      <= '0;
      rot_q      <= 1'b0;
      dir_q      <= 1'b0;
      rsp_q      <= '0;
      start_q    <= 1'b0;
      valid_q    <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            gnt_q   <= grant[1];
            data_q  <= grant[1] ? bus.req1_data : bus.req0_data;
            sel_q   <= grant[1] ? bus.req1_select : bus.req0_select;
            rot_q   <= grant[1] ? bus.req1_rot : bus.req0_rot;
            dir_q   <= grant[1] ? bus.req1_dir : bus.req0_dir;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          rsp_q   <= bus.sh_data_out;
          valid_q <= gnt_q ? 2'b10 : 2'b01;
          state   <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[gnt_q]) begin
            valid_q    <= 2'b00;
            busy_q     <= 1'b0;
            last_grant <= gnt_q;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_shift_arbiter;

  localparam int DW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  shift_arbiter_if #(.DATA_SIZE(DW), .SEL_WIDTH(SW)) bus ();

  shift_arbiter #(.DATA_SIZE(DW), .SEL_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] shf(
    input logic [DW-1:0] d,
    input int s,
    input bit rot,
    input bit dir
  );
    int v;
    int r;
    v = int'(d);
    if (s == 0) r = v;
    else if (!dir) r = rot ? (((v << s) | (v >> (DW - s))) & 15)
                           : ((v << s) & 15);
    else r = rot ? (((v >> s) | (v << (DW - s))) & 15)
                 : (v >> s);
    return DW'(r);
  endfunction

  // Shifter: registered, one cycle latency.
  always @(posedge clk)
    bus.sh_data_out <= shf(bus.sh_data_in, int'(bus.sh_select),
                           bus.sh_rotation, bus.sh_direction);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Model: age = cycles since acceptance (0 = idle).
  int            m_age  = 0;
  bit            m_g    = 1'b0;
  bit            m_last = 1'b1;
  logic [DW-1:0] m_d    = '0;
  logic [SW-1:0] m_s    = '0;
  bit            m_rot  = 1'b0;
  bit            m_dir  = 1'b0;
  logic [DW-1:0] m_r    = '0;

  always @(negedge clk) begin
    logic [1:0] eg;
    logic [1:0] ev;
    eg = 2'b00;
    if (!rst && m_age == 0) begin
      case (bus.req_valid)
        2'b01:   eg = 2'b01;
        2'b10:   eg = 2'b10;
        2'b11:   eg = m_last ? 2'b01 : 2'b10;
        default: eg = 2'b00;
      endcase
    end
    ev = (m_age >= 3) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    if (chk_en) begin
      chk("req_ready", bus.req_ready, eg);
      chk("sh_start", bus.sh_start, m_age == 1);
      chk("busy", bus.busy, m_age != 0);
      chk("sh_data_in", bus.sh_data_in, m_d);
      chk("sh_select", bus.sh_select, m_s);
      chk("sh_rotation", bus.sh_rotation, m_rot);
      chk("sh_direction", bus.sh_direction, m_dir);
      chk("rsp_valid", bus.rsp_valid, ev);
      chk("rsp_data", bus.rsp_data, m_r);
    end
    if (rst) begin
      m_age  = 0;
      m_g    = 1'b0;
      m_last = 1'b1;
      m_d    = '0;
      m_s    = '0;
      m_rot  = 1'b0;
      m_dir  = 1'b0;
      m_r    = '0;
    end else if (m_age == 0) begin
      if (eg != 2'b00) begin
        m_age = 1;
        m_g   = eg[1];
        m_d   = eg[1] ? bus.req1_data : bus.req0_data;
        m_s   = eg[1] ? bus.req1_select : bus.req0_select;
        m_rot = eg[1] ? bus.req1_rot : bus.req0_rot;
        m_dir = eg[1] ? bus.req1_dir : bus.req0_dir;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age = 3;
      m_r   = shf(m_d, int'(m_s), m_rot, m_dir);
    end else if (bus.rsp_ready[m_g]) begin
      m_age  = 0;
      m_last = m_g;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      #1;
      if (bus.req_ready[i]) ok = 1'b1;
      else tick();
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    int tq[$];
    bus.req_valid   = 2'b00;
    bus.req0_data   = '0;
    bus.req1_data   = '0;
    bus.req0_select = '0;
    bus.req1_select = '0;
    bus.req0_rot    = 1'b0;
    bus.req1_rot    = 1'b0;
    bus.req0_dir    = 1'b0;
    bus.req1_dir    = 1'b0;
    bus.rsp_ready   = 2'b00;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_sh_start", bus.sh_start, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);

    // Single request: 1011 >> 1 logical = 0101
    bus.req0_data   = 4'b1011;
    bus.req0_select = 2'd1;
    bus.req0_rot    = 1'b0;
    bus.req0_dir    = 1'b1;
    bus.req_valid   = 2'b01;
    wait_grant(0, "single");
    chk("single_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("single_sh_start", bus.sh_start, 1);
    chk("single_sh_data_in", bus.sh_data_in, 4'b1011);
    tick();
    tick();
    chk("single_rsp_valid", bus.rsp_valid, 2'b01);
    chk("single_rsp_data", bus.rsp_data, 4'b0101);
    bus.rsp_ready = 2'b01;
    tick();
    chk("single_idle", bus.busy, 0);

    // Contention after reset: req0 first, then req1 (1001 rotl 1 = 0011)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req1_data   = 4'b1001;
    bus.req1_select = 2'd1;
    bus.req1_rot    = 1'b1;
    bus.req1_dir    = 1'b0;
    bus.rsp_ready   = 2'b11;
    bus.req_valid   = 2'b11;
    #1;
    chk("cont_first", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b10;
    wait_grant(1, "cont_second");
    chk("cont_second", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    tick();
    tick();
    chk("cont_rsp_valid", bus.rsp_valid, 2'b10);
    chk("cont_rsp_data", bus.rsp_data, 4'b0011);
    tick();

    // Fairness: both held, grants alternate every 4 cycles
    bus.req_valid = 2'b11;
    for (int k = 0; k < 40 && gq.size() < 4; k++) begin
      #1;
      if (|bus.req_ready) begin
        gq.push_back(int'(bus.req_ready[1]));
        tq.push_back(cyc);
      end
      tick();
    end
    bus.req_valid = 2'b00;
    chk("fair_count", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++)
      chk("fair_order", gq[i], i % 2);
    for (int i = 1; i < tq.size(); i++)
      chk("fair_period", tq[i] - tq[i-1], 4);
    repeat (5) tick();

    // Backpressure, then wrong-bit ready while serving requester 0
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b11;
    wait_grant(0, "bp");
    tick();
    tick();
    tick();
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
      chk("bp_rsp_data", bus.rsp_data, 4'b0101);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_busy", bus.busy, 1);
      bus.rsp_ready = (k >= 4) ? 2'b10 : 2'b00;
      tick();
    end
    chk("wrongbit_hold", bus.rsp_valid, 2'b01);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    tick();
    chk("bp_done", bus.busy, 0);

    // Reset in WAIT abandons the transaction
    bus.req0_data = 4'b0110;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    wait_grant(0, "rmid");
    tick();
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_sh_start", bus.sh_start, 0);
    chk("rmid_rsp_valid", bus.rsp_valid, 0);
    chk("rmid_busy", bus.busy, 0);
    chk("rmid_sh_data_in", bus.sh_data_in, 0);
    chk("rmid_sh_select", bus.sh_select, 0);
    chk("rmid_rsp_data", bus.rsp_data, 0);
    chk("rmid_req_ready", bus.req_ready, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rmid_no_rsp", bus.rsp_valid, 0);
      tick();
    end
    bus.req_valid = 2'b11;
    #1;
    chk("rmid_grant0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
